mem_writeback_stage: RTL

//   Memory + writeback pipeline stage downstream of decode/execute. Consumes the

---
 rtl/pipeline_pkg.sv | 28 ++
 rtl/load_align.sv | 38 +++
 rtl/mem_writeback_stage.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types and constants for the memory/writeback stage
//
// Contents:
//   DATA_W, REG_W : default datapath and register-address widths
//   state_t       : memory-stage FSM states (IDLE, WAIT)
//   lane_be()     : byte-lane enable table, lane index -> one-hot mem_be
package pipeline_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  function automatic logic [3:0] lane_be(input logic [1:0] lane);
    logic [3:0] be;
    case (lane)
      2'd0:    be = 4'b0001;
      2'd1:    be = 4'b0010;
      2'd2:    be = 4'b0100;
      default: be = 4'b1000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - byte-lane alignment for loads and stores
//
// Ports:
//   lane        in   2       byte lane (address bits [1:0])
//   byte_sel    in   1       1 = byte access, 0 = word access
//   rdata       in   DATA_W  word returned by memory
//   store_data  in   DATA_W  register value to be stored
//   load_value  out  DATA_W  register-file value for a load (sign-extended byte or word)
//   wdata       out  DATA_W  store data (low byte replicated to all lanes for byte stores)
//   be          out  4       byte enables (one-hot lane for byte, all lanes for word)
module load_align
  import pipeline_pkg::*;
(
  input  logic [1:0]        lane,
  input  logic              byte_sel,
  input  logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] store_data,
  output logic [DATA_W-1:0] load_value,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        be
);

  logic [7:0] lane_byte;

  always_comb begin
    lane_byte  = rdata[{lane, 3'b000} +: 8];
    load_value = rdata;
    wdata      = store_data;
    be         = 4'hF;
    if (byte_sel) begin
      load_value = {{(DATA_W-8){lane_byte[7]}}, lane_byte};
      // Replicating the byte lets memory pick it up from whichever lane be selects.
      wdata      = {(DATA_W/8){store_data[7:0]}};
      be         = lane_be(lane);
    end
  end

endmodule

// File: rtl/mem_writeback_stage.sv
// rtl/mem_writeback_stage.sv - memory access and register writeback pipeline stage
//
// Ports:
//   clk, reset                    clock (rising edge), synchronous active-low reset
//   valid_in                      instruction from execute is valid
//   alu_result, store_data        ALU result / effective address, store source value
//   addr_d_in, write_in           destination register and its write enable
//   read_mmu, write_mmu, byte_sel load, store (wins if both), byte access
//   stall                         hold upstream (combinational)
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_be             memory request, held through WAIT
//   mem_ready, mem_rdata          memory completion and read word
//   rf_write, rf_addr, rf_data    register-file write port (one-cycle pulse)
//   stall_count                   saturating count of WAIT cycles
module mem_writeback_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic [REG_W-1:0]  addr_d_in,
  input  logic              write_in,
  input  logic              read_mmu,
  input  logic              write_mmu,
  input  logic              byte_sel,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rf_write,
  output logic [REG_W-1:0]  rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic [CNT_W-1:0]  stall_count
);

  import pipeline_pkg::*;

  state_t state_q, state_d;
  logic   accept;
  logic   retire;

  logic [REG_W-1:0]  lat_dest;
  logic              lat_byte;
  logic [1:0]        lat_lane;

  logic [1:0]        align_lane;
  logic              align_byte;
  logic [DATA_W-1:0] load_value;
  logic [DATA_W-1:0] align_wdata;
  logic [3:0]        align_be;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    retire  = 1'b0;
    stall   = 1'b0;
    mem_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_in && (read_mmu || write_mmu)) begin
          accept  = 1'b1;
          stall   = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        mem_req = 1'b1;
        stall   = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One aligner serves both directions: in IDLE it shapes the incoming store,
  // in WAIT it extracts the load result from the latched lane.
  assign align_lane = (state_q == WAIT) ? lat_lane : alu_result[1:0];
  assign align_byte = (state_q == WAIT) ? lat_byte : byte_sel;

  load_align u_load_align (
    .lane       (align_lane),
    .byte_sel   (align_byte),
    .rdata      (mem_rdata),
    .store_data (store_data),
    .load_value (load_value),
    .wdata      (align_wdata),
    .be         (align_be)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_be      <= 4'h0;
      rf_write    <= 1'b0;
      rf_addr     <= '0;
      rf_data     <= '0;
      stall_count <= '0;
      lat_dest    <= '0;
      lat_byte    <= 1'b0;
      lat_lane    <= 2'd0;
    end else begin
      rf_write <= 1'b0;

      if (accept) begin
        mem_we    <= write_mmu;
        mem_addr  <= {alu_result[DATA_W-1:2], 2'b00};
        mem_wdata <= align_wdata;
        mem_be    <= align_be;
        lat_dest  <= addr_d_in;
        lat_byte  <= byte_sel;
        lat_lane  <= alu_result[1:0];
      end else if (state_q == IDLE && valid_in) begin
        rf_write <= write_in && (addr_d_in != '0);
        rf_addr  <= addr_d_in;
        rf_data  <= alu_result;
      end

      if (state_q == WAIT && stall_count != {CNT_W{1'b1}})
        stall_count <= stall_count + CNT_W'(1);

      if (retire && !mem_we) begin
        rf_write <= (lat_dest != '0);
        rf_addr  <= lat_dest;
        rf_data  <= load_value;
      end
    end
  end

endmodule
